// File: rtl/clock_pkg.sv
// Shared definitions for the clock-chain counters.
//
// Contents:
//   cnt_mode_e  - counter operating mode (RUN counts ticks, SET takes buttons)
//   SEC_MOD, MIN_MOD, HOUR_MOD - moduli of the standard time stages
//   bcd2_t      - two-digit packed BCD value {tens, ones}
package clock_pkg;

    typedef enum logic {
        CNT_RUN = 1'b0,
        CNT_SET = 1'b1
    } cnt_mode_e;

    localparam int SEC_MOD  = 60;
    localparam int MIN_MOD  = 60;
    localparam int HOUR_MOD = 24;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

endpackage

// File: rtl/bin2bcd_2dig.sv
// Combinational binary to two-digit BCD converter.
//
// Ports:
//   bin  in  [7:0]  binary value, expected range 0..99
//   bcd  out bcd2_t tens/ones digits of bin
//
// Inputs above 99 produce a tens digit above 9; the caller guarantees range.
module bin2bcd_2dig
    import clock_pkg::*;
(
    input  logic [7:0] bin,
    output bcd2_t      bcd
);

    always_comb begin
        bcd.tens = 4'(bin / 8'd10);
        bcd.ones = 4'(bin % 8'd10);
    end

endmodule

// File: rtl/mod_time_counter.sv
// Parametrised modulo-N time-unit counter for the clock chain.
//
// Counts on an incoming tick, wraps at MODULUS-1 and emits a registered
// one-cycle carry (up-wrap) or borrow (down-wrap) pulse for the next stage.
// A RUN/SET mode lets the user adjust the value with inc/dec buttons without
// generating carries. Stages are chained carry_out -> next stage tick.
//
// Parameters:
//   MODULUS  count range 0..MODULUS-1, legal 2..256
//   WIDTH    derived count width (not overridable)
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   tick       in   one-cycle advance pulse from the previous stage
//   en         in   count enable; tick ignored when 0
//   dir        in   0 = up, 1 = down
//   load       in   synchronous load strobe (highest priority)
//   load_val   in   value to load, saturated to MODULUS-1
//   set_req    in   pulse: toggle RUN <-> SET
//   inc / dec  in   pulses: +1 / -1 while in SET (both together = no change)
//   count      out  current value
//   carry_out  out  registered pulse on up-wrap in RUN
//   borrow_out out  registered pulse on down-wrap in RUN
//   at_max     out  combinational count == MODULUS-1
//   in_set     out  registered mode state, 1 while in SET
//   bcd        out  (only with MOD_TIME_COUNTER_BCD_EN) registered BCD of
//                   count, one cycle behind count; needs MODULUS <= 100
//
// Input pulses are sampled on the rising clock edge; each is acted on once
// per edge it is high. Outputs change only on the rising edge (or reset),
// except at_max which follows count combinationally.
module mod_time_counter
    import clock_pkg::*;
#(
    parameter  int MODULUS = 60,
    localparam int WIDTH   = $clog2(MODULUS)
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             set_req,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             carry_out,
    output logic             borrow_out,
    output logic             at_max,
    output logic             in_set
`ifdef MOD_TIME_COUNTER_BCD_EN
    ,
    output logic [7:0]       bcd
`endif
);

    if (MODULUS < 2 || MODULUS > 256) begin : g_bad_modulus
        $error("mod_time_counter: MODULUS %0d outside 2..256", MODULUS);
    end

    // One spare bit so MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MODULUS - 1);

    cnt_mode_e        mode_q, mode_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             in_set_q;

    logic [WIDTH:0]   count_ext;
    logic [WIDTH:0]   load_ext;
    logic [WIDTH:0]   next_up;
    logic [WIDTH:0]   next_dn;
    logic             is_max;
    logic             is_zero;

    always_comb begin
        count_ext = {1'b0, count_q};
        load_ext  = {1'b0, load_val};
        is_max    = (count_ext == MAX_EXT);
        is_zero   = (count_ext == '0);
        next_up   = is_max  ? '0      : count_ext + 1'b1;
        next_dn   = is_zero ? MAX_EXT : count_ext - 1'b1;

        count_d  = count_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        mode_d   = mode_q;

        if (set_req) begin
            mode_d = (mode_q == CNT_RUN) ? CNT_SET : CNT_RUN;
        end

        // Value update is judged against the pre-toggle mode.
        if (load) begin
            count_d = (load_ext >= MOD_EXT) ? MAX_EXT[WIDTH-1:0] : load_val;
        end else if (mode_q == CNT_SET) begin
            if (inc && !dec) begin
                count_d = next_up[WIDTH-1:0];
            end else if (dec && !inc) begin
                count_d = next_dn[WIDTH-1:0];
            end
        end else if (tick && en) begin
            if (dir) begin
                count_d  = next_dn[WIDTH-1:0];
                borrow_d = is_zero;
            end else begin
                count_d  = next_up[WIDTH-1:0];
                carry_d  = is_max;
            end
        end
    end

    // Mode FSM and counter state share one register block; in_set is the
    // registered decode of the next mode so it tracks mode_q exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q   <= CNT_RUN;
            count_q  <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            in_set_q <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            count_q  <= count_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            in_set_q <= (mode_d == CNT_SET);
        end
    end

    assign count      = count_q;
    assign carry_out  = carry_q;
    assign borrow_out = borrow_q;
    assign at_max     = is_max;
    assign in_set     = in_set_q;

`ifdef MOD_TIME_COUNTER_BCD_EN
    if (MODULUS > 100) begin : g_bad_bcd
        $error("mod_time_counter: bcd output needs MODULUS <= 100, got %0d", MODULUS);
    end

    bcd2_t bcd_conv;
    bcd2_t bcd_q;

    bin2bcd_2dig u_bin2bcd (
        .bin (8'(count_q)),
        .bcd (bcd_conv)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcd_q <= '0;
        end else begin
            bcd_q <= bcd_conv;
        end
    end

    assign bcd = bcd_q;
`endif

endmodule

// File: tb/tb_mod_time_counter.sv
// Bench for mod_time_counter: a seconds stage (MODULUS 60) chained into an
// hours-style stage (MODULUS 24). Table-driven vectors on the first stage,
// then hand-written wrap, async-reset and cascade sequences.
module tb_mod_time_counter;
    import clock_pkg::*;

    logic       clk;
    logic       reset;

    // Stage 0: modulus 60
    logic       tick, en, dir, load, set_req, inc, dec;
    logic [5:0] load_val;
    logic [5:0] count;
    logic       carry_out, borrow_out, at_max, in_set;

    // Stage 1: modulus 24, ticked by stage 0 carry
    logic       hr_en, hr_dir, hr_load, hr_set_req, hr_inc, hr_dec;
    logic [4:0] hr_load_val;
    logic [4:0] hr_count;
    logic       hr_carry, hr_borrow, hr_at_max, hr_in_set;

`ifdef MOD_TIME_COUNTER_BCD_EN
    logic [7:0] bcd, hr_bcd;
`endif

    mod_time_counter #(.MODULUS(SEC_MOD)) u_sec (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .en         (en),
        .dir        (dir),
        .load       (load),
        .load_val   (load_val),
        .set_req    (set_req),
        .inc        (inc),
        .dec        (dec),
        .count      (count),
        .carry_out  (carry_out),
        .borrow_out (borrow_out),
        .at_max     (at_max),
        .in_set     (in_set)
`ifdef MOD_TIME_COUNTER_BCD_EN
        ,
        .bcd        (bcd)
`endif
    );

    mod_time_counter #(.MODULUS(HOUR_MOD)) u_hr (
        .clk        (clk),
        .reset      (reset),
        .tick       (carry_out),
        .en         (hr_en),
        .dir        (hr_dir),
        .load       (hr_load),
        .load_val   (hr_load_val),
        .set_req    (hr_set_req),
        .inc        (hr_inc),
        .dec        (hr_dec),
        .count      (hr_count),
        .carry_out  (hr_carry),
        .borrow_out (hr_borrow),
        .at_max     (hr_at_max),
        .in_set     (hr_in_set)
`ifdef MOD_TIME_COUNTER_BCD_EN
        ,
        .bcd        (hr_bcd)
`endif
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int passes = 0;
    logic [5:0] exp_q[$];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        int ld, lv, tk, en_i, dr, sr, ic, dc;
        int e_cnt, e_cy, e_br, e_mx, e_set;
    } vec_t;

    function automatic vec_t mk(input int ld, input int lv, input int tk, input int en_i,
                                input int dr, input int sr, input int ic, input int dc,
                                input int e_cnt, input int e_cy, input int e_br,
                                input int e_mx, input int e_set);
        vec_t v;
        v.ld = ld; v.lv = lv; v.tk = tk; v.en_i = en_i; v.dr = dr;
        v.sr = sr; v.ic = ic; v.dc = dc;
        v.e_cnt = e_cnt; v.e_cy = e_cy; v.e_br = e_br; v.e_mx = e_mx; v.e_set = e_set;
        return v;
    endfunction

    localparam int NVEC = 25;
    vec_t vecs[NVEC];

    // ---------------- driver tasks ----------------
    // Present inputs at the falling edge, let one rising edge act, then
    // return 1 time unit after that edge with the pulse inputs cleared.
    task automatic drive(input vec_t v);
        @(negedge clk);
        load     = v.ld[0];
        load_val = 6'(v.lv);
        tick     = v.tk[0];
        en       = v.en_i[0];
        dir      = v.dr[0];
        set_req  = v.sr[0];
        inc      = v.ic[0];
        dec      = v.dc[0];
        @(posedge clk);
        #1;
        load    = 1'b0;
        tick    = 1'b0;
        set_req = 1'b0;
        inc     = 1'b0;
        dec     = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    int sec_pulses;
    int hr_pulses;
    int cy_hi;

    initial begin
        reset = 1'b0;
        tick = 0; en = 1; dir = 0; load = 0; set_req = 0; inc = 0; dec = 0;
        load_val = '0;
        hr_en = 1; hr_dir = 0; hr_load = 0; hr_set_req = 0; hr_inc = 0; hr_dec = 0;
        hr_load_val = '0;

        //          ld lv tk en dr sr ic dc | cnt cy br mx set
        vecs[0]  = mk(0, 0, 1, 1, 1, 0, 0, 0,  59, 0, 1, 1, 0); // down-wrap from 0
        vecs[1]  = mk(0, 0, 1, 1, 0, 0, 0, 0,   0, 1, 0, 0, 0); // up-wrap from 59
        vecs[2]  = mk(0, 0, 1, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0); // en=0 ignores tick
        vecs[4]  = mk(1, 63, 0, 1, 0, 0, 0, 0, 59, 0, 0, 1, 0); // load saturates
        vecs[5]  = mk(1, 17, 0, 1, 0, 0, 0, 0, 17, 0, 0, 0, 0);
        vecs[6]  = mk(1, 5, 1, 1, 0, 0, 0, 0,   5, 0, 0, 0, 0); // load beats tick
        vecs[7]  = mk(0, 0, 0, 1, 0, 1, 0, 0,   5, 0, 0, 0, 1); // enter SET
        vecs[8]  = mk(0, 0, 1, 1, 0, 0, 0, 0,   5, 0, 0, 0, 1); // tick ignored in SET
        vecs[9]  = mk(0, 0, 0, 1, 0, 0, 1, 0,   6, 0, 0, 0, 1);
        vecs[10] = mk(0, 0, 0, 1, 0, 0, 0, 1,   5, 0, 0, 0, 1);
        vecs[11] = mk(0, 0, 0, 1, 0, 0, 1, 1,   5, 0, 0, 0, 1); // inc+dec cancel
        vecs[12] = mk(1, 58, 0, 1, 0, 0, 0, 0, 58, 0, 0, 0, 1); // load keeps SET
        vecs[13] = mk(0, 0, 0, 1, 0, 0, 1, 0,  59, 0, 0, 1, 1);
        vecs[14] = mk(0, 0, 0, 1, 0, 0, 1, 0,   0, 0, 0, 0, 1); // SET wrap, no carry
        vecs[15] = mk(0, 0, 0, 1, 0, 0, 0, 1,  59, 0, 0, 1, 1); // SET wrap, no borrow
        vecs[16] = mk(0, 0, 0, 1, 0, 1, 1, 0,   0, 0, 0, 0, 0); // inc uses old mode SET
        vecs[17] = mk(0, 0, 1, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0); // ticks resume
        vecs[18] = mk(0, 0, 1, 1, 0, 1, 0, 0,   2, 0, 0, 0, 1); // tick uses old mode RUN
        vecs[19] = mk(0, 0, 0, 1, 0, 1, 1, 0,   3, 0, 0, 0, 0);
        vecs[20] = mk(0, 0, 0, 1, 0, 0, 1, 0,   3, 0, 0, 0, 0); // inc ignored in RUN
        vecs[21] = mk(0, 0, 1, 1, 1, 0, 0, 0,   2, 0, 0, 0, 0);
        vecs[22] = mk(1, 60, 0, 1, 0, 0, 0, 0, 59, 0, 0, 1, 0); // load == MODULUS
        vecs[23] = mk(0, 0, 1, 1, 0, 0, 0, 0,   0, 1, 0, 0, 0);
        vecs[24] = mk(1, 10, 1, 1, 1, 0, 0, 0, 10, 0, 0, 0, 0); // load, no borrow

        // ---- reset state ----
        #12;
        check("rst_count", int'(count), 0);
        check("rst_carry", int'(carry_out), 0);
        check("rst_borrow", int'(borrow_out), 0);
        check("rst_in_set", int'(in_set), 0);
        check("rst_hr_count", int'(hr_count), 0);
        @(negedge clk);
        reset = 1'b1;

        // ---- table ----
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i]);
            check($sformatf("v%0d_count", i), int'(count), vecs[i].e_cnt);
            check($sformatf("v%0d_carry", i), int'(carry_out), vecs[i].e_cy);
            check($sformatf("v%0d_borrow", i), int'(borrow_out), vecs[i].e_br);
            check($sformatf("v%0d_at_max", i), int'(at_max), vecs[i].e_mx);
            check($sformatf("v%0d_in_set", i), int'(in_set), vecs[i].e_set);
        end

        // ---- wrap up: 60 ticks from reset ----
        do_reset();
        dir = 1'b0;
        en  = 1'b1;
        cy_hi = 0;
        for (int i = 1; i <= 60; i++) begin
            exp_q.push_back(6'(i % 60));
            drive(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            check("wrap_count", int'(count), int'(exp_q.pop_front()));
            check("wrap_carry", int'(carry_out), (i == 60) ? 1 : 0);
            check("wrap_borrow", int'(borrow_out), 0);
            check("wrap_at_max", int'(at_max), (i == 59) ? 1 : 0);
            if (carry_out) cy_hi++;
`ifdef MOD_TIME_COUNTER_BCD_EN
            if (i == 60) check("wrap_bcd", int'(bcd), 'h59);
`endif
        end
        drive(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check("wrap_carry_clear", int'(carry_out), 0);
        check("wrap_carry_cycles", cy_hi, 1);

        // ---- async reset while in SET ----
        drive(mk(1, 42, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        drive(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        check("pre_arst_count", int'(count), 42);
        check("pre_arst_in_set", int'(in_set), 1);
        #2;                      // mid-cycle, no clock edge follows before checks
        reset = 1'b0;
        #1;
        check("arst_count", int'(count), 0);
        check("arst_in_set", int'(in_set), 0);
        check("arst_carry", int'(carry_out), 0);
        @(negedge clk);
        reset = 1'b1;
        drive(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check("post_arst_count", int'(count), 1);

        // ---- cascade 60 -> 24 ----
        do_reset();
        sec_pulses = 0;
        hr_pulses  = 0;
        dir  = 1'b0;
        tick = 1'b1;
        for (int i = 1; i <= 1440; i++) begin
            @(posedge clk);
            #1;
            if (carry_out) sec_pulses++;
            if (hr_carry) hr_pulses++;
            if (i == 600) begin
                // stage 1 sees the 10th carry one edge later
                check("casc600_sec", int'(count), 0);
                check("casc600_hr", int'(hr_count), 9);
            end
            if (i == 1440) begin
                check("casc_hr_at_max", int'(hr_at_max), 1);
            end
        end
        @(negedge clk);
        tick = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (carry_out) sec_pulses++;
            if (hr_carry) hr_pulses++;
        end
        check("casc_sec_count", int'(count), 0);
        check("casc_hr_count", int'(hr_count), 0);
        check("casc_sec_pulses", sec_pulses, 24);
        check("casc_hr_pulses", hr_pulses, 1);
        check("casc_hr_borrow", int'(hr_borrow), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
